uart_rx_pkt_ctrl: RTL and testbench
===================================

// Module: uart_rx_pkt_ctrl
// PURPOSE
//  Packet-level controller behind the uart_rx byte receiver, in the clk_3125 domain.
//  - Framing: hunts for SOF, then takes LEN, LEN payload bytes and CHK.
//  - Checks: parity, length, checksum and inter-byte timeout.
//  - Buffers the payload and releases it on a valid/ready byte stream only if the packet is good.
// PARAMETERS
//  SOF           8'hA5  start-of-frame byte
//  MAX_LEN       16     max payload bytes (buffer depth); LEN in 1..MAX_LEN
//  TIMEOUT_CLKS  1000   max clk_3125 cycles between bytes inside a packet
// PORTS
//  clk_3125     in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  rx_msg       in   8  byte from uart_rx
//  rx_parity    in   1  parity flag from uart_rx; valid with rx_complete
//  rx_complete  in   1  one-cycle strobe: rx_msg/rx_parity valid
//  out_data     out  8  payload byte
//  out_valid    out  1  out_data valid
//  out_ready    in   1  consumer accepts byte when out_valid & out_ready
//  out_last     out  1  qualifies final payload byte
//  pkt_ok       out  1  pulse: good packet, drain starting
//  err_code     out  3  0 none, 1 parity, 2 len, 3 chk, 4 timeout, 5 overrun; valid with err_stb
//  err_stb      out  1  one-cycle error pulse
// BEHAVIOUR
//  Reset: state=HUNT; all outputs 0; pointers, counters, checksum 0. Reset mid-packet discards it.
//  A byte event is rx_complete=1 at a clk_3125 edge. It is consumed on that edge, with no backpressure to uart_rx.
//  Parity error: rx_parity != ^rx_msg on a byte event in LEN, PAY or CHK.
//    -> err_code=1, go to HUNT. The byte is discarded.
//  FSM:
//   HUNT: byte==SOF -> LEN. Any other byte is ignored silently.
//   LEN:  byte in 1..MAX_LEN -> latch len, chk=byte, wr_ptr=0, go to PAY.
//         Otherwise err_code=2, go to HUNT.
//   PAY:  buf[wr_ptr]=byte, chk^=byte, wr_ptr++. Go to CHK when wr_ptr reaches len-1 on this byte.
//   CHK:  byte==chk -> pkt_ok pulse, rd_ptr=0, go to DRAIN.
//         Mismatch -> err_code=3, go to HUNT.
//   DRAIN: out_valid=1 from the cycle after the CHK byte (latency 1); out_data=buf[rd_ptr].
//         out_last=(rd_ptr==len-1).
//         Handshake -> rd_ptr++. Handshake on last -> out_valid=0 next cycle, go to HUNT.
//         Byte event in DRAIN: dropped, err_code=5. DRAIN continues. The byte is not checked for SOF.
//  out_data/out_last are held stable while out_valid & !out_ready.
//  Timeout: gap counter is cleared on every byte event and in HUNT/DRAIN, and counts in LEN/PAY/CHK.
//    Reaching TIMEOUT_CLKS-1 -> err_code=4, go to HUNT.
//    If a byte event and the timeout hit in the same cycle, the byte wins and the counter clears.
//  err_stb/pkt_ok are high for exactly 1 cycle; err_code holds its value until the next err_stb.
//  Widths: len/pointers are $clog2(MAX_LEN+1) bits; chk is 8-bit XOR with no carry; pointers never wrap, bounded by len.
// STRUCTURE
//  Shared package uart_pkg:
//   - state encodings HUNT/LEN/PAY/CHK/DRAIN
//   - err_code constants
//   - SOF default
//   - CLKS_PER_BIT (shared with uart_rx)
//  Sub-module uart_pkt_buf: MAX_LEN x 8 register file with 1 write port and 1 async read port.
//  The FSM, pointers and timeout counter stay in this module.
// TESTING
//  1 A5,03,11,22,33,CHK=03^11^22^33=03 -> pkt_ok; out 11,22,33; out_last on 33; back to HUNT.
//  2 Same packet with CHK=04 -> err_stb, err_code=3; no out_valid.
//  3 A5,00 -> err_code=2; A5,11 (MAX_LEN=16) -> err_code=2. Next A5,01,7E,7F -> pkt_ok, out 7E.
//  4 A5,02,AA then no byte for TIMEOUT_CLKS cycles -> err_code=4. A byte landing on the limit cycle -> no error.
//  5 Good 2-byte packet with out_ready=0 for 50 cycles, plus one byte event during DRAIN.
//    -> err_code=5; out_data held; both payload bytes still delivered in order.
//  6 rst pulse while in PAY -> all outputs 0, state HUNT; next good packet is delivered intact.
//  Bench also asserts: rx_parity mismatch gives err_code=1; err_stb and pkt_ok never high together.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx byte receiver and its packet controller.
package uart_pkg;

  // 3.125 MHz system clock / 115200 baud, rounded.
  localparam int unsigned CLKS_PER_BIT = 27;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_HUNT  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_PAY   = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CHK     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  function automatic logic parity_ok(input logic [7:0] data, input logic flag);
    return flag == ^data;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, one async read port.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: storage has no reset; every entry is written before the drain can read it.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: frames SOF/LEN/payload/CHK, validates the
// packet and streams the buffered payload out only when the packet is good.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF          = SOF_DEFAULT,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1000
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic [7:0] rx_msg,
  input  logic       rx_parity,
  input  logic       rx_complete,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic [2:0] err_code,
  output logic       err_stb
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          err_stb_q, err_stb_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          buf_we;
  logic [7:0]    rd_data;
  logic          in_frame, par_bad, last_beat, handshake;

  uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk_3125),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_msg),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign in_frame  = (state_q == ST_LEN) || (state_q == ST_PAY) || (state_q == ST_CHK);
  assign par_bad   = !parity_ok(rx_msg, rx_parity);
  assign out_valid = (state_q == ST_DRAIN);
  assign last_beat = (rd_ptr_q == len_q - LW'(1));
  assign out_last  = out_valid && last_beat;
  assign out_data  = out_valid ? rd_data : 8'h00;
  assign handshake = out_valid && out_ready;
  assign pkt_ok    = pkt_ok_q;
  assign err_stb   = err_stb_q;
  assign err_code  = err_code_q;

  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    chk_d      = chk_q;
    gap_d      = gap_q;
    err_code_d = err_code_q;
    err_stb_d  = 1'b0;
    pkt_ok_d   = 1'b0;
    buf_we     = 1'b0;

    if (rx_complete && in_frame && par_bad) begin
      err_stb_d  = 1'b1;
      err_code_d = ERR_PARITY;
      state_d    = ST_HUNT;
    end else if (rx_complete) begin
      case (state_q)
        ST_HUNT: if (rx_msg == SOF) state_d = ST_LEN;
        ST_LEN: begin
          if (rx_msg != 8'd0 && rx_msg <= 8'(MAX_LEN)) begin
            len_d    = rx_msg[LW-1:0];
            chk_d    = rx_msg;
            wr_ptr_d = '0;
            state_d  = ST_PAY;
          end else begin
            err_stb_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_HUNT;
          end
        end
        ST_PAY: begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ rx_msg;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q == len_q - LW'(1)) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (rx_msg == chk_q) begin
            pkt_ok_d = 1'b1;
            rd_ptr_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_stb_d  = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_HUNT;
          end
        end
        ST_DRAIN: begin
          err_stb_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // The drain runs regardless of dropped overrun bytes.
    if (handshake) begin
      if (last_beat) state_d = ST_HUNT;
      else           rd_ptr_d = rd_ptr_q + LW'(1);
    end

    if (!in_frame || rx_complete) begin
      gap_d = '0;
    end else if (gap_q == TW'(TIMEOUT_CLKS - 1)) begin
      gap_d      = '0;
      err_stb_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_HUNT;
    end else begin
      gap_d = gap_q + TW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      chk_q      <= '0;
      gap_q      <= '0;
      err_code_q <= ERR_NONE;
      err_stb_q  <= 1'b0;
      pkt_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      chk_q      <= chk_d;
      gap_q      <= gap_d;
      err_code_q <= err_code_d;
      err_stb_q  <= err_stb_d;
      pkt_ok_q   <= pkt_ok_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: directed packet scenarios plus
// randomized packets scored against a packet-level expectation model.
module tb_uart_rx_pkt_ctrl;

  localparam int         MAX_LEN      = 16;
  localparam int         TIMEOUT_CLKS = 1000;
  localparam logic [7:0] SOF          = 8'hA5;

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_msg = 8'h00;
  logic       rx_parity = 1'b0;
  logic       rx_complete = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, pkt_ok, err_stb;
  logic [2:0] err_code;

  uart_rx_pkt_ctrl #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .rx_msg      (rx_msg),
    .rx_parity   (rx_parity),
    .rx_complete (rx_complete),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_ok      (pkt_ok),
    .err_code    (err_code),
    .err_stb     (err_stb)
  );

  always #5 clk_3125 = ~clk_3125;

  int         n_checks = 0;
  int         n_fail = 0;
  string      scen = "reset";
  int         ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
  logic [7:0] pl_q[$];
  logic [7:0] got_q[$], exp_q[$];
  logic       got_last_q[$], exp_last_q[$];
  logic [2:0] err_q[$], exp_err_q[$];
  int         ok_cnt = 0;
  int         exp_ok = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (%s): got %0h expected %0h", tag, scen, got, exp);
    end
  endtask

  always @(posedge clk_3125) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: collects delivered bytes and error pulses, checks holding.
  always @(negedge clk_3125) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (err_stb || pkt_ok) check("stb_excl", err_stb & pkt_ok, 0);
      if (err_stb) err_q.push_back(err_code);
      if (pkt_ok) ok_cnt <= ok_cnt + 1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
      end
    end
    prev_stall <= !rst && out_valid && !out_ready;
    prev_data  <= out_data;
    prev_last  <= out_last;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_3125);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par_good);
    rx_msg      = b;
    rx_parity   = par_good ? ^b : ~^b;
    rx_complete = 1'b1;
    @(posedge clk_3125);
    #1;
    rx_complete = 1'b0;
  endtask

  function automatic logic [7:0] pkt_chk();
    logic [7:0] c;
    c = 8'(pl_q.size());
    foreach (pl_q[i]) c ^= pl_q[i];
    return c;
  endfunction

  // Byte k after SOF: 0 is LEN, 1..n payload, n+1 CHK.
  function automatic logic [7:0] pkt_byte(input int k, input logic [7:0] chk_flip);
    if (k == 0) return 8'(pl_q.size());
    if (k <= pl_q.size()) return pl_q[k-1];
    return pkt_chk() ^ chk_flip;
  endfunction

  task automatic send_seq(input int upto, input int bad_at, input logic [7:0] chk_flip,
                          input int gap_max);
    send_byte(SOF, 1'b1);
    for (int k = 0; k <= upto; k++) begin
      idle($urandom_range(0, gap_max));
      send_byte(pkt_byte(k, chk_flip), k != bad_at);
    end
  endtask

  task automatic expect_pkt();
    foreach (pl_q[i]) begin
      exp_q.push_back(pl_q[i]);
      exp_last_q.push_back(i == pl_q.size() - 1);
    end
    exp_ok++;
  endtask

  task automatic finish_pkt();
    int budget;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 600) begin
      idle(1);
      budget++;
    end
    idle(3);
    check("n_bytes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("data", got_q[i], exp_q[i]);
      check("last", got_last_q[i], exp_last_q[i]);
    end
    check("n_err", err_q.size(), exp_err_q.size());
    for (int i = 0; i < err_q.size() && i < exp_err_q.size(); i++)
      check("err_code", err_q[i], exp_err_q[i]);
    check("n_pkt_ok", ok_cnt, exp_ok);
    check("idle_valid", out_valid, 0);
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
    err_q.delete(); exp_err_q.delete();
    ok_cnt = 0;
    exp_ok = 0;
  endtask

  task automatic check_all_zero();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_err_stb", err_stb, 0);
    check("rst_err_code", err_code, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_3125);
    @(negedge clk_3125);
    check_all_zero();
    @(posedge clk_3125);
    #1;
    rst = 1'b0;
    idle(2);

    scen = "t1_good";
    pl_q = '{8'h11, 8'h22, 8'h33};
    check("t1_chk_model", pkt_chk(), 8'h03);
    send_seq(4, -1, 8'h00, 0);
    @(negedge clk_3125);
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_pkt_ok", pkt_ok, 1);
    check("t1_first_data", out_data, 8'h11);
    check("t1_first_last", out_last, 0);
    expect_pkt();
    finish_pkt();

    scen = "t2_badchk";
    send_seq(4, -1, 8'h07, 1);  // CHK becomes 04
    exp_err_q.push_back(3'd3);
    finish_pkt();

    scen = "t3_len";
    send_byte(SOF, 1); send_byte(8'h00, 1);
    send_byte(SOF, 1); send_byte(8'h11, 1);
    exp_err_q.push_back(3'd2);
    exp_err_q.push_back(3'd2);
    pl_q = '{8'h7E};
    send_seq(2, -1, 8'h00, 0);
    expect_pkt();
    finish_pkt();

    scen = "parity";
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_seq(1, 1, 8'h00, 0);
    exp_err_q.push_back(3'd1);
    finish_pkt();

    scen = "t6_reset";
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(2, -1, 8'h00, 0);
    rst = 1'b1;
    @(negedge clk_3125);
    check_all_zero();
    @(posedge clk_3125);
    #1;
    rst = 1'b0;
    pl_q = '{8'h5C, 8'hA5, 8'h3D};
    send_seq(4, -1, 8'h00, 2);
    expect_pkt();
    finish_pkt();

    scen = "t4_timeout";
    pl_q = '{8'hAA, 8'hBB};
    send_seq(1, -1, 8'h00, 0);
    idle(TIMEOUT_CLKS - 1);
    check("to_early", err_q.size(), 0);
    idle(1);
    @(negedge clk_3125);
    check("to_stb", err_stb, 1);
    check("to_code", err_code, 3'd4);
    exp_err_q.push_back(3'd4);
    finish_pkt();

    scen = "t4_limit";
    send_seq(1, -1, 8'h00, 0);
    idle(TIMEOUT_CLKS - 1);
    send_byte(8'hBB, 1);
    send_byte(8'h13, 1);
    expect_pkt();
    finish_pkt();

    scen = "t5_stall";
    ready_mode = 2;
    pl_q = '{8'h5A, 8'hC3};
    send_seq(3, -1, 8'h00, 0);
    send_byte(SOF, 1);
    exp_err_q.push_back(3'd5);
    idle(50);
    check("t5_stall_valid", out_valid, 1);
    check("t5_stall_data", out_data, 8'h5A);
    ready_mode = 0;
    expect_pkt();
    finish_pkt();

    for (int it = 0; it < 24; it++) begin
      int n, fault, gap_max;
      logic [7:0] bad_len;
      scen = $sformatf("rand%0d", it);
      n = $urandom_range(1, MAX_LEN);
      fault = $urandom_range(0, 5);
      gap_max = $urandom_range(0, 3);
      pl_q.delete();
      for (int j = 0; j < n; j++) pl_q.push_back(8'($urandom_range(0, 255)));
      ready_mode = (fault == 5) ? 2 : $urandom_range(0, 1);
      case (fault)
        2: begin
          send_seq(n + 1, -1, 8'($urandom_range(1, 255)), gap_max);
          exp_err_q.push_back(3'd3);
        end
        3: begin
          int pos;
          pos = $urandom_range(0, n + 1);
          send_seq(pos, pos, 8'h00, gap_max);
          exp_err_q.push_back(3'd1);
        end
        4: begin
          bad_len = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
          send_byte(SOF, 1);
          send_byte(bad_len, 1);
          exp_err_q.push_back(3'd2);
        end
        5: begin
          send_seq(n + 1, -1, 8'h00, gap_max);
          send_byte(8'($urandom_range(0, 255)), 1);
          exp_err_q.push_back(3'd5);
          ready_mode = 1;
          expect_pkt();
        end
        default: begin
          send_seq(n + 1, -1, 8'h00, gap_max);
          expect_pkt();
        end
      endcase
      finish_pkt();
      ready_mode = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
